mem_stage: RTL

Memory-access stage of the MIPS32 pipeline, between EX_MEM and MEM_WB. Executes loads and stores over a single-outstanding request/acknowledge data bus, aligns and sign/zero-extends load data, and forwards register, HI/LO and CP0 write-back controls to MEM_WB. Multi-cycle accesses are covered by a stall request to the pipeline controller; the instruction is held in EX_MEM until the access completes.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_load_ext.sv | 33 +++
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MIPS32 memory-access stage: memop encodings,
// FSM state encoding and byte-enable constants.
package mem_pkg;

    typedef enum logic [3:0] {
        MEMOP_NOP = 4'd0,
        MEMOP_LB  = 4'd1,
        MEMOP_LBU = 4'd2,
        MEMOP_LH  = 4'd3,
        MEMOP_LHU = 4'd4,
        MEMOP_LW  = 4'd5,
        MEMOP_SB  = 4'd6,
        MEMOP_SH  = 4'd7,
        MEMOP_SW  = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Big-endian lanes: bit 3 of the byte enable covers data bits 31:24.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEMOP_LB)  || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
               (op == MEMOP_LHU) || (op == MEMOP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-data lane selection and sign/zero extension for the memory stage.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [3:0]  memop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_lane = rdata_i[31:24];
            2'd1:    byte_lane = rdata_i[23:16];
            2'd2:    byte_lane = rdata_i[15:8];
            default: byte_lane = rdata_i[7:0];
        endcase

        half_lane = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];

        case (memop_i)
            MEMOP_LB:  result_o = {{24{byte_lane[7]}}, byte_lane};
            MEMOP_LBU: result_o = {24'd0, byte_lane};
            MEMOP_LH:  result_o = {{16{half_lane[15]}}, half_lane};
            MEMOP_LHU: result_o = {16'd0, half_lane};
            default:   result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: single-outstanding req/ack data bus, load
// extension and write-back forwarding. Optional macro: MEM_ALIGN_EXC_EN.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [3:0]  memop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] store_data_i,
    input  logic        wreg_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  whilo_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_addr_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stallreq_o,
    output logic        wreg_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic [1:0]  whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_addr_o
`ifdef MEM_ALIGN_EXC_EN
   ,output logic        exc_adel_o,
    output logic        exc_ades_o,
    output logic [31:0] bad_vaddr_o
`endif
);

    state_e      state_q, state_d;
    logic        abort_q, abort_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        op_load, op_store, accept, kill, in_idle, in_busy, in_done;
    logic [1:0]  addr_lo_eff;
    logic [3:0]  sel_req;
    logic [31:0] wdata_req;
    logic [31:0] load_result;
`ifdef MEM_ALIGN_EXC_EN
    logic        misaligned;
`endif

    mem_load_ext u_load_ext (
        .memop_i   (op_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (rdata_q),
        .result_o  (load_result)
    );

    // Request decode: effective low address bits, lane enables, store data.
    always_comb begin
        op_load     = is_load(memop_i);
        op_store    = is_store(memop_i);
        in_idle     = (state_q == ST_IDLE);
        in_busy     = (state_q == ST_BUSY);
        in_done     = (state_q == ST_DONE);
        addr_lo_eff = mem_addr_i[1:0];
        sel_req     = BE_NONE;
        wdata_req   = store_data_i;
`ifdef MEM_ALIGN_EXC_EN
        misaligned  = 1'b0;
`endif
        case (memop_i)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: begin
                sel_req   = BE_BYTE0 >> addr_lo_eff;
                wdata_req = {4{store_data_i[7:0]}};
            end
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: begin
`ifdef MEM_ALIGN_EXC_EN
                misaligned = mem_addr_i[0];
`endif
                addr_lo_eff = {mem_addr_i[1], 1'b0};
                sel_req     = mem_addr_i[1] ? BE_LO_HALF : BE_HI_HALF;
                wdata_req   = {2{store_data_i[15:0]}};
            end
            MEMOP_LW, MEMOP_SW: begin
`ifdef MEM_ALIGN_EXC_EN
                misaligned = |mem_addr_i[1:0];
`endif
                addr_lo_eff = 2'b00;
                sel_req     = BE_WORD;
            end
            default: ;
        endcase

`ifdef MEM_ALIGN_EXC_EN
        accept = in_idle & (op_load | op_store) & ~flush & ~misaligned;
`else
        accept = in_idle & (op_load | op_store) & ~flush;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            abort_q     <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_sel_q   <= BE_NONE;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            op_q        <= MEMOP_NOP;
            addr_lo_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            abort_q     <= abort_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        abort_d     = abort_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_BUSY;
                    abort_d     = 1'b0;
                    bus_we_d    = op_store;
                    bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                    bus_sel_d   = sel_req;
                    bus_wdata_d = wdata_req;
                    op_d        = memop_i;
                    addr_lo_d   = addr_lo_eff;
                end
            end
            ST_BUSY: begin
                // A flush cannot cut the handshake short; it only marks the
                // access so its data is dropped once the ack arrives.
                if (flush)
                    abort_d = 1'b1;
                if (bus_ack_i) begin
                    abort_d = 1'b0;
                    if (abort_q | flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        rdata_d = bus_rdata_i;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        kill        = flush | abort_q;
        bus_req_o   = in_busy;
        bus_we_o    = bus_we_q;
        bus_addr_o  = bus_addr_q;
        bus_sel_o   = bus_sel_q;
        bus_wdata_o = bus_wdata_q;
        stallreq_o  = accept | in_busy;

        waddr_o    = waddr_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        cp0_addr_o = cp0_addr_i;
        wdata_o    = (in_done & is_load(op_q)) ? load_result : wdata_i;

        // Loads only reach MEM_WB in the cycle their data is ready.
        wreg_o   = (op_load & ~in_done) ? 1'b0 : wreg_i;
        whilo_o  = whilo_i;
        cp0_we_o = cp0_we_i;
        if (kill) begin
            wreg_o   = 1'b0;
            whilo_o  = 2'b00;
            cp0_we_o = 1'b0;
        end

`ifdef MEM_ALIGN_EXC_EN
        exc_adel_o  = in_idle & op_load & misaligned & ~flush;
        exc_ades_o  = in_idle & op_store & misaligned & ~flush;
        bad_vaddr_o = mem_addr_i;
`endif
    end

endmodule
